ip_rx_parser: RTL and testbench

Parametrised IPv4 receive parser between the MAC receive AXI-Stream and the UDP/ICMP/TCP handlers. It strips the Ethernet and IPv4 headers, including any IPv4 options, and forwards only the IP payload. Ethernet padding is trimmed using the IP Total Length field. The header checksum is checked over the full IHL length, and unwanted frames are dropped. Per-frame error flags are reported on the payload's tlast beat.

---
 rtl/ip_rx_parser_if.sv | 31 +++
 rtl/ip_rx_parser.sv | 181 ++++++++++++++++++
 tb/tb_ip_rx_parser.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_rx_parser_if.sv
// MAC receive byte stream in, IP payload stream plus frame metadata out.
// master: the MAC side (drives the byte stream, observes the parser outputs).
// slave : the parser.
interface ip_rx_parser_if;
  logic [7:0]  rx_axis_mac_tdata;
  logic        rx_axis_mac_tvalid;
  logic        rx_axis_mac_tlast;
  logic        rx_axis_mac_tuser;

  logic [7:0]  rx_axis_ip_tdata;
  logic        rx_axis_ip_tvalid;
  logic        rx_axis_ip_tlast;
  logic [2:0]  rx_axis_ip_tuser;
  logic [1:0]  rx_axis_ip_tdest;
  logic [7:0]  rx_ip_proto;
  logic [31:0] rx_ip_src;
  logic [31:0] rx_ip_dst;
  logic [15:0] rx_ip_len;

  modport master (
    output rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
    input  rx_axis_ip_tdata, rx_axis_ip_tvalid, rx_axis_ip_tlast, rx_axis_ip_tuser,
           rx_axis_ip_tdest, rx_ip_proto, rx_ip_src, rx_ip_dst, rx_ip_len
  );

  modport slave (
    input  rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
    output rx_axis_ip_tdata, rx_axis_ip_tvalid, rx_axis_ip_tlast, rx_axis_ip_tuser,
           rx_axis_ip_tdest, rx_ip_proto, rx_ip_src, rx_ip_dst, rx_ip_len
  );
endinterface

// File: rtl/ip_rx_parser.sv
// IPv4 receive parser: strips Ethernet + IPv4 header (incl. options), trims
// Ethernet padding via Total Length, checks the header checksum and drops
// non-IPv4 / fragmented / unsupported-protocol frames.
// Optional build macro IP_RX_DST_FILTER_EN: compile in the destination
// address filter (LOCAL_IP, plus broadcast when ACCEPT_BCAST = 1).
module ip_rx_parser #(
  parameter logic [31:0] LOCAL_IP     = 32'hC0A8_0002,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          PROTO_TCP_EN = 1'b0
) (
  input  logic          rx_mac_aclk,
  input  logic          rx_mac_resetn,
  ip_rx_parser_if.slave bus
);
  typedef enum logic [2:0] {S_ETH, S_HDR, S_PAY, S_PAD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q;
  logic [7:0]  etype_hi_q, ver_ihl_q, proto_q, csum_hi_q;
  logic [15:0] tot_len_q, pay_cnt_q;
  logic [13:0] frag_q;
  logic [31:0] src_q, dst_q;
  logic [19:0] acc_q;
  logic [7:0]  hold_q;
  logic        hold_vld_q, flush_q, csum_err_q;
  logic [2:0]  flush_user_q;

  logic        beat, last;
  logic [7:0]  d;
  logic [3:0]  ihl;
  logic [5:0]  hdr_bytes;
  logic [7:0]  hdr_last;
  logic        at_hdr_end, csum_bad, proto_ok, dst_ok, hdr_drop;
  logic [19:0] sum;
  logic [16:0] f1;
  logic [15:0] f2, pay_len;
  logic [31:0] dst_full;

  assign beat      = bus.rx_axis_mac_tvalid;
  assign last      = bus.rx_axis_mac_tlast;
  assign d         = bus.rx_axis_mac_tdata;
  assign ihl       = ver_ihl_q[3:0];
  assign hdr_bytes = {ihl, 2'b00};
  // A bogus IHL (< 5) still walks a 20-byte header so the frame can be judged.
  assign hdr_last  = (ihl < 4'd5) ? 8'd19 : {2'b00, hdr_bytes} - 8'd1;
  assign at_hdr_end = (state_q == S_HDR) && (idx_q == hdr_last);

  // Ones-complement check including the final word still on the bus.
  assign sum      = acc_q + {4'h0, csum_hi_q, d};
  assign f1       = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
  assign f2       = f1[15:0] + {15'b0, f1[16]};
  assign csum_bad = (f2 != 16'hFFFF);

  // With IHL = 5 the last destination byte is the current beat.
  assign dst_full = (idx_q == 8'd19) ? {dst_q[23:0], d} : dst_q;
  assign pay_len  = tot_len_q - {10'b0, hdr_bytes};
  assign proto_ok = (proto_q == 8'h11) || (proto_q == 8'h01) ||
                    (PROTO_TCP_EN && (proto_q == 8'h06));

`ifdef IP_RX_DST_FILTER_EN
  assign dst_ok = (dst_full == LOCAL_IP) ||
                  (ACCEPT_BCAST && (dst_full == 32'hFFFF_FFFF));
`else
  logic dst_filter_unused;
  assign dst_filter_unused = ^{LOCAL_IP, ACCEPT_BCAST};
  assign dst_ok = 1'b1;
`endif

  assign hdr_drop = (ver_ihl_q[7:4] != 4'd4) || (ihl < 4'd5) ||
                    frag_q[13] || (frag_q[12:0] != 13'd0) || !proto_ok ||
                    (tot_len_q <= {10'b0, hdr_bytes}) || !dst_ok;

  // State register.
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) state_q <= S_ETH;
    else                state_q <= state_d;
  end

  // Next-state: every MAC tlast returns to ETH; otherwise advance per byte.
  always_comb begin
    state_d = state_q;
    if (beat) begin
      unique case (state_q)
        S_ETH:  if (last) state_d = S_ETH;
                else if (idx_q == 8'd13)
                  state_d = ({etype_hi_q, d} == 16'h0800) ? S_HDR : S_DROP;
        S_HDR:  if (last) state_d = S_ETH;
                else if (at_hdr_end) state_d = hdr_drop ? S_DROP : S_PAY;
        S_PAY:  if (last) state_d = S_ETH;
                else if (pay_cnt_q == 16'd1) state_d = S_PAD;
        S_PAD:  if (last) state_d = S_ETH;
        S_DROP: if (last) state_d = S_ETH;
        default: state_d = S_ETH;
      endcase
    end
  end

  // Header capture, checksum accumulation, payload hold register and outputs.
  always_ff @(posedge rx_mac_aclk or negedge rx_mac_resetn) begin
    if (!rx_mac_resetn) begin
      idx_q <= '0; etype_hi_q <= '0; ver_ihl_q <= '0; proto_q <= '0;
      csum_hi_q <= '0; tot_len_q <= '0; pay_cnt_q <= '0; frag_q <= '0;
      src_q <= '0; dst_q <= '0; acc_q <= '0; hold_q <= '0;
      hold_vld_q <= 1'b0; flush_q <= 1'b0; csum_err_q <= 1'b0; flush_user_q <= '0;
      bus.rx_axis_ip_tdata <= '0; bus.rx_axis_ip_tvalid <= 1'b0;
      bus.rx_axis_ip_tlast <= 1'b0; bus.rx_axis_ip_tuser <= '0;
      bus.rx_axis_ip_tdest <= '0; bus.rx_ip_proto <= '0;
      bus.rx_ip_src <= '0; bus.rx_ip_dst <= '0; bus.rx_ip_len <= '0;
    end else begin
      bus.rx_axis_ip_tvalid <= 1'b0;
      bus.rx_axis_ip_tlast  <= 1'b0;
      bus.rx_axis_ip_tuser  <= '0;
      // Final byte of a frame that ended inside PAY goes out one beat late.
      if (flush_q) begin
        bus.rx_axis_ip_tvalid <= 1'b1;
        bus.rx_axis_ip_tdata  <= hold_q;
        bus.rx_axis_ip_tlast  <= 1'b1;
        bus.rx_axis_ip_tuser  <= flush_user_q;
        hold_vld_q <= 1'b0;
        flush_q    <= 1'b0;
      end
      if (beat) begin
        idx_q <= (last || state_d != state_q) ? 8'd0 : idx_q + 8'd1;
        unique case (state_q)
          S_ETH: begin
            acc_q <= '0;
            if (idx_q == 8'd12) etype_hi_q <= d;
          end
          S_HDR: begin
            if (idx_q[0]) acc_q <= sum;
            else          csum_hi_q <= d;
            case (idx_q)
              8'd0:  ver_ihl_q <= d;
              8'd2:  tot_len_q[15:8] <= d;
              8'd3:  tot_len_q[7:0] <= d;
              8'd6:  frag_q[13:8] <= d[5:0];
              8'd7:  frag_q[7:0] <= d;
              8'd9:  proto_q <= d;
              8'd12, 8'd13, 8'd14, 8'd15: src_q <= {src_q[23:0], d};
              8'd16, 8'd17, 8'd18, 8'd19: dst_q <= {dst_q[23:0], d};
              default: ;
            endcase
            if (at_hdr_end && !last && !hdr_drop) begin
              pay_cnt_q       <= pay_len;
              csum_err_q      <= csum_bad;
              bus.rx_ip_proto <= proto_q;
              bus.rx_ip_src   <= src_q;
              bus.rx_ip_dst   <= dst_full;
              bus.rx_ip_len   <= pay_len;
              bus.rx_axis_ip_tdest <= (proto_q == 8'h01) ? 2'd1 :
                                      (proto_q == 8'h06) ? 2'd2 : 2'd0;
            end
          end
          S_PAY: begin
            if (hold_vld_q) begin
              bus.rx_axis_ip_tvalid <= 1'b1;
              bus.rx_axis_ip_tdata  <= hold_q;
            end
            hold_q     <= d;
            hold_vld_q <= 1'b1;
            pay_cnt_q  <= pay_cnt_q - 16'd1;
            if (last) begin
              flush_q      <= 1'b1;
              flush_user_q <= {pay_cnt_q != 16'd1, csum_err_q, bus.rx_axis_mac_tuser};
            end
          end
          S_PAD: begin
            if (last) begin
              bus.rx_axis_ip_tvalid <= 1'b1;
              bus.rx_axis_ip_tdata  <= hold_q;
              bus.rx_axis_ip_tlast  <= 1'b1;
              bus.rx_axis_ip_tuser  <= {1'b0, csum_err_q, bus.rx_axis_mac_tuser};
              hold_vld_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ip_rx_parser.sv
// Directed, table-driven bench for ip_rx_parser: builds Ethernet/IPv4 frames
// with a locally computed header checksum and checks forwarded payload,
// tlast/tuser/tdest and the captured header fields.
module tb_ip_rx_parser;
  localparam logic [31:0] LIP = 32'hC0A8_0002;
  localparam logic [31:0] SIP = 32'hC0A8_0001;
`ifdef IP_RX_DST_FILTER_EN
  localparam int FILT_BEATS = 0;
`else
  localparam int FILT_BEATS = 8;
`endif

  typedef struct {
    string       name;
    logic [15:0] etype;
    int          ihl;
    logic [15:0] tot_len;
    bit          mf;
    logic [7:0]  proto;
    logic [31:0] dst;
    int          pay_sent;
    int          pad;
    bit          corrupt;
    bit          mac_err;
    bit          gaps;
    bit          chk_lat;
    int          exp_beats;
    logic [1:0]  exp_dest;
    logic [2:0]  exp_user;
    logic [15:0] exp_len;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  ip_rx_parser_if bus();

  ip_rx_parser #(.LOCAL_IP(LIP), .ACCEPT_BCAST(1'b1), .PROTO_TCP_EN(1'b0)) dut (
    .rx_mac_aclk   (clk),
    .rx_mac_resetn (rst_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fq[$];
  logic [7:0] od[$];
  logic       ol[$];
  logic [2:0] ou[$];
  logic [1:0] ot[$];
  int tlast_cyc = 0;
  int olast_cyc = 0;

  // Output monitor, sampled 1 ns after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && bus.rx_axis_ip_tvalid) begin
      od.push_back(bus.rx_axis_ip_tdata);
      ol.push_back(bus.rx_axis_ip_tlast);
      ou.push_back(bus.rx_axis_ip_tuser);
      ot.push_back(bus.rx_axis_ip_tdest);
      if (bus.rx_axis_ip_tlast) olast_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pay_byte(input int seed, input int i);
    return 8'((i * 13) + 5 + (seed * 31));
  endfunction

  task automatic clear_mon();
    od.delete(); ol.delete(); ou.delete(); ot.delete();
  endtask

  task automatic build(input int seed, input frame_t f);
    logic [7:0]  h[60];
    int          hl;
    int          s;
    logic [15:0] ck;
    hl = f.ihl * 4;
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(8'hFF);
    for (int i = 0; i < 6; i++) fq.push_back(8'h02);
    fq.push_back(f.etype[15:8]);
    fq.push_back(f.etype[7:0]);
    for (int i = 0; i < 60; i++) h[i] = (i >= 20) ? 8'h01 : 8'h00;
    h[0] = {4'h4, 4'(f.ihl)};
    h[2] = f.tot_len[15:8];  h[3] = f.tot_len[7:0];
    h[4] = 8'h12;            h[5] = 8'h34;
    h[6] = {2'b00, f.mf, 5'b0};
    h[8] = 8'h40;            h[9] = f.proto;
    h[12] = SIP[31:24]; h[13] = SIP[23:16]; h[14] = SIP[15:8]; h[15] = SIP[7:0];
    h[16] = f.dst[31:24]; h[17] = f.dst[23:16]; h[18] = f.dst[15:8]; h[19] = f.dst[7:0];
    s = 0;
    for (int i = 0; i < hl; i += 2) s += int'({h[i], h[i+1]});
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~16'(s);
    h[10] = ck[15:8]; h[11] = ck[7:0];
    if (f.corrupt) h[8] = h[8] ^ 8'h10;
    for (int i = 0; i < hl; i++) fq.push_back(h[i]);
    for (int i = 0; i < f.pay_sent; i++) fq.push_back(pay_byte(seed, i));
    for (int i = 0; i < f.pad; i++) fq.push_back(8'hAA);
  endtask

  // Drives fq (or its first n bytes with n_only) one byte per negedge.
  task automatic send(input bit mac_err, input bit gaps, input int n_only);
    int n;
    n = (n_only > 0) ? n_only : fq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps && (i % 7 == 3)) begin
        bus.rx_axis_mac_tvalid = 1'b0;
        bus.rx_axis_mac_tlast  = 1'b0;
        @(negedge clk);
      end
      bus.rx_axis_mac_tvalid = 1'b1;
      bus.rx_axis_mac_tdata  = fq[i];
      bus.rx_axis_mac_tlast  = (n_only == 0) && (i == n - 1);
      bus.rx_axis_mac_tuser  = (n_only == 0) && (i == n - 1) && mac_err;
      if (bus.rx_axis_mac_tlast) tlast_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_axis_mac_tvalid = 1'b0;
      bus.rx_axis_mac_tlast  = 1'b0;
      bus.rx_axis_mac_tuser  = 1'b0;
    end
  endtask

  task automatic check_frame(input string nm, input int seed, input frame_t f);
    int errs;
    int lerr;
    chk({nm, ".beats"}, 64'(od.size()), 64'(f.exp_beats));
    if (f.exp_beats > 0 && od.size() == f.exp_beats) begin
      errs = 0;
      lerr = 0;
      for (int i = 0; i < od.size(); i++) begin
        if (od[i] !== pay_byte(seed, i)) errs++;
        if (i < od.size() - 1 && (ol[i] !== 1'b0 || ou[i] !== 3'b000)) lerr++;
      end
      chk({nm, ".data_errs"}, 64'(errs), 64'd0);
      chk({nm, ".early_tlast_or_tuser"}, 64'(lerr), 64'd0);
      chk({nm, ".tlast"}, 64'(ol[od.size()-1]), 64'd1);
      chk({nm, ".tuser"}, 64'(ou[od.size()-1]), 64'(f.exp_user));
      chk({nm, ".tdest"}, 64'(ot[od.size()-1]), 64'(f.exp_dest));
      chk({nm, ".ip_len"}, 64'(bus.rx_ip_len), 64'(f.exp_len));
      chk({nm, ".ip_proto"}, 64'(bus.rx_ip_proto), 64'(f.proto));
      chk({nm, ".ip_src"}, 64'(bus.rx_ip_src), 64'(SIP));
      chk({nm, ".ip_dst"}, 64'(bus.rx_ip_dst), 64'(f.dst));
      if (f.chk_lat) chk({nm, ".tlast_latency"}, 64'(olast_cyc - tlast_cyc), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".stream"}, 64'({bus.rx_axis_ip_tvalid, bus.rx_axis_ip_tlast,
        bus.rx_axis_ip_tuser, bus.rx_axis_ip_tdest, bus.rx_axis_ip_tdata}), 64'd0);
    chk({nm, ".src"}, 64'(bus.rx_ip_src), 64'd0);
    chk({nm, ".dst"}, 64'(bus.rx_ip_dst), 64'd0);
    chk({nm, ".len_proto"}, 64'({bus.rx_ip_len, bus.rx_ip_proto}), 64'd0);
  endtask

  frame_t tbl[10];
  frame_t fr;

  initial begin
    tbl[0] = '{"udp",      16'h0800, 5, 16'd28,  1'b0, 8'h11, LIP,          8,  18, 1'b0, 1'b0, 1'b0, 1'b1, 8,  2'd0, 3'b000, 16'd8};
    tbl[1] = '{"icmp_opt", 16'h0800, 7, 16'd36,  1'b0, 8'h01, LIP,          8,  10, 1'b0, 1'b0, 1'b1, 1'b0, 8,  2'd1, 3'b000, 16'd8};
    tbl[2] = '{"csum_mac", 16'h0800, 5, 16'd28,  1'b0, 8'h11, LIP,          8,  18, 1'b1, 1'b1, 1'b0, 1'b0, 8,  2'd0, 3'b011, 16'd8};
    tbl[3] = '{"short",    16'h0800, 5, 16'd100, 1'b0, 8'h11, LIP,          30, 0,  1'b0, 1'b0, 1'b0, 1'b0, 30, 2'd0, 3'b100, 16'd80};
    tbl[4] = '{"arp",      16'h0806, 5, 16'd28,  1'b0, 8'h11, LIP,          8,  18, 1'b0, 1'b0, 1'b0, 1'b0, 0,  2'd0, 3'b000, 16'd0};
    tbl[5] = '{"mf",       16'h0800, 5, 16'd28,  1'b1, 8'h11, LIP,          8,  18, 1'b0, 1'b0, 1'b0, 1'b0, 0,  2'd0, 3'b000, 16'd0};
    tbl[6] = '{"tcp_off",  16'h0800, 5, 16'd28,  1'b0, 8'h06, LIP,          8,  18, 1'b0, 1'b0, 1'b0, 1'b0, 0,  2'd0, 3'b000, 16'd0};
    tbl[7] = '{"min",      16'h0800, 5, 16'd21,  1'b0, 8'h11, LIP,          1,  0,  1'b0, 1'b0, 1'b0, 1'b0, 1,  2'd0, 3'b000, 16'd1};
    tbl[8] = '{"dst_other",16'h0800, 5, 16'd28,  1'b0, 8'h11, 32'h0A00_0009, 8, 18, 1'b0, 1'b0, 1'b0, 1'b0, FILT_BEATS, 2'd0, 3'b000, 16'd8};
    tbl[9] = '{"bcast",    16'h0800, 5, 16'd30,  1'b0, 8'h01, 32'hFFFF_FFFF, 10, 16, 1'b0, 1'b0, 1'b0, 1'b0, 10, 2'd1, 3'b000, 16'd10};

    bus.rx_axis_mac_tdata  = '0;
    bus.rx_axis_mac_tvalid = 1'b0;
    bus.rx_axis_mac_tlast  = 1'b0;
    bus.rx_axis_mac_tuser  = 1'b0;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // Table sweep, idle gap between frames.
    for (int e = 0; e < 10; e++) begin
      clear_mon();
      build(e, tbl[e]);
      send(tbl[e].mac_err, tbl[e].gaps, 0);
      idle(6);
      check_frame(tbl[e].name, e, tbl[e]);
    end

    // Rejected frames back to back, then a good frame with no idle cycle.
    clear_mon();
    build(4, tbl[4]); send(1'b0, 1'b0, 0);
    build(5, tbl[5]); send(1'b0, 1'b0, 0);
    build(6, tbl[6]); send(1'b0, 1'b0, 0);
    build(0, tbl[0]); send(1'b0, 1'b0, 0);
    idle(6);
    check_frame("b2b_after_drops", 0, tbl[0]);

    // Two good frames back to back: first tlast overlaps second's byte 0.
    clear_mon();
    build(7, tbl[7]); send(1'b0, 1'b0, 0);
    fr = tbl[7];
    chk("b2b_min_first.tlast_pending", 64'(od.size()), 64'd0);
    build(0, tbl[0]); send(1'b0, 1'b0, 0);
    idle(6);
    chk("b2b_min.total_beats", 64'(od.size()), 64'd9);
    if (od.size() == 9) begin
      chk("b2b_min.first_byte", 64'(od[0]), 64'(pay_byte(7, 0)));
      chk("b2b_min.first_tlast", 64'(ol[0]), 64'd1);
    end

    // Reset in the middle of the payload, then a fresh frame.
    clear_mon();
    fr = tbl[0];
    fr.tot_len = 16'd40; fr.pay_sent = 20; fr.pad = 6;
    build(3, fr);
    send(1'b0, 1'b0, 14 + 20 + 6);
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx_axis_mac_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check_reset_outputs("mid_reset");
    end
    @(negedge clk) rst_n = 1'b1;
    clear_mon();
    build(0, tbl[0]);
    send(1'b0, 1'b0, 0);
    idle(6);
    check_frame("after_reset", 0, tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
